// File: rtl/score_keeper_if.sv
// score_keeper_if -- signal bundle between the game logic / display side and
// the score keeper.
//
//   master : drives mode, start, pass_0, pass_1, crash, frame_tick;
//            observes the display outputs.
//   slave  : the score keeper itself.
//
//   mode        1  0 = single player, 1 = two player (sampled in IDLE)
//   start       1  level, rising edge starts / ends a game
//   pass_0/1    1  level, each rising edge = one pipe cleared
//   crash       1  level, high = game over
//   frame_tick  1  one-cycle pulse at start of vertical blanking
//   binary      8  frame-stable player 0 score (high score in IDLE)
//   binary_1    8  frame-stable player 1 score (0 in single player)
//   mode_out    1  frame-stable game mode
//   state       2  00 IDLE, 01 PLAY, 10 OVER
//   bcd_digits 12  {hundreds, tens, ones} of binary
//   bcd_valid   1  bcd_digits matches binary
interface score_keeper_if;
   logic        mode;
   logic        start;
   logic        pass_0;
   logic        pass_1;
   logic        crash;
   logic        frame_tick;
   logic [7:0]  binary;
   logic [7:0]  binary_1;
   logic        mode_out;
   logic [1:0]  state;
   logic [11:0] bcd_digits;
   logic        bcd_valid;

   modport master (
      output mode, start, pass_0, pass_1, crash, frame_tick,
      input  binary, binary_1, mode_out, state, bcd_digits, bcd_valid
   );

   modport slave (
      input  mode, start, pass_0, pass_1, crash, frame_tick,
      output binary, binary_1, mode_out, state, bcd_digits, bcd_valid
   );
endinterface

// File: rtl/score_keeper.sv
// score_keeper -- game score FSM with frame-synchronous display registers and
// a sequential shift-add-3 binary-to-BCD converter.
//
// Ports:
//   clk  1  system clock, all registers on rising edge
//   rst  1  synchronous reset, active-high
//   sk      score_keeper_if.slave (see interface file for signal list)
//
// Build option: define HIGH_SCORE_EN to keep a high-score register that is
// updated on entering OVER and shown on binary while IDLE. Without it binary
// shows 0 in IDLE.
//
// state | meaning
// IDLE  | waiting for start edge; display shows high score (or 0)
// PLAY  | counting pass edges; crash moves to OVER
// OVER  | scores frozen; start edge returns to IDLE
module score_keeper (
   input  logic          clk,
   input  logic          rst,
   score_keeper_if.slave sk
);

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      PLAY = 2'b01,
      OVER = 2'b10
   } state_t;

   state_t      st;
   logic        start_q, start_qq;
   logic        pass_0_q, pass_0_qq;
   logic        pass_1_q, pass_1_qq;
   logic        crash_q;
   logic        start_edge, pass_0_edge, pass_1_edge;
   logic [7:0]  score_0, score_1;
   logic [7:0]  score_0_nxt, score_1_nxt;
   logic        inc_0, inc_1;
   logic        mode_lat;
   logic [7:0]  bin_nxt;
   logic [19:0] conv;
   logic [3:0]  conv_cnt;
   logic        conv_busy;

   assign start_edge  = start_q  & ~start_qq;
   assign pass_0_edge = pass_0_q & ~pass_0_qq;
   assign pass_1_edge = pass_1_q & ~pass_1_qq;

   // Internal mode follows start immediately so score_1 gating is right from
   // the first pass; mode_out only follows it at frame boundaries.
   always_comb begin
      inc_0       = (st == PLAY) && pass_0_edge && (score_0 != 8'hff);
      inc_1       = (st == PLAY) && pass_1_edge && mode_lat && (score_1 != 8'hff);
      score_0_nxt = score_0 + {7'd0, inc_0};
      score_1_nxt = score_1 + {7'd0, inc_1};
   end

`ifdef HIGH_SCORE_EN
   logic [7:0] high_score;
   logic [7:0] hs_max;

   // Uses next-cycle scores so a pass edge in the crash cycle is included.
   always_comb begin
      hs_max = high_score;
      if (score_0_nxt > hs_max) hs_max = score_0_nxt;
      if (score_1_nxt > hs_max) hs_max = score_1_nxt;
   end

   always_ff @(posedge clk) begin
      if (rst)
         high_score <= 8'd0;
      else if (st == PLAY && crash_q)
         high_score <= hs_max;
   end

   always_comb begin
      bin_nxt = (st == IDLE) ? high_score : score_0;
   end
`else
   always_comb begin
      bin_nxt = (st == IDLE) ? 8'd0 : score_0;
   end
`endif

   // One shift-add-3 step on {hundreds, tens, ones, binary}.
   function automatic logic [19:0] bcd_step(input logic [19:0] v);
      logic [19:0] t;
      t = v;
      if (t[19:16] >= 4'd5) t[19:16] = t[19:16] + 4'd3;
      if (t[15:12] >= 4'd5) t[15:12] = t[15:12] + 4'd3;
      if (t[11:8]  >= 4'd5) t[11:8]  = t[11:8]  + 4'd3;
      return {t[18:0], 1'b0};
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         st            <= IDLE;
         start_q       <= 1'b0;
         start_qq      <= 1'b0;
         pass_0_q      <= 1'b0;
         pass_0_qq     <= 1'b0;
         pass_1_q      <= 1'b0;
         pass_1_qq     <= 1'b0;
         crash_q       <= 1'b0;
         score_0       <= 8'd0;
         score_1       <= 8'd0;
         mode_lat      <= 1'b0;
         sk.binary     <= 8'd0;
         sk.binary_1   <= 8'd0;
         sk.mode_out   <= 1'b0;
         sk.bcd_digits <= 12'd0;
         sk.bcd_valid  <= 1'b1;
         conv          <= 20'd0;
         conv_cnt      <= 4'd0;
         conv_busy     <= 1'b0;
      end else begin
         start_q   <= sk.start;
         start_qq  <= start_q;
         pass_0_q  <= sk.pass_0;
         pass_0_qq <= pass_0_q;
         pass_1_q  <= sk.pass_1;
         pass_1_qq <= pass_1_q;
         crash_q   <= sk.crash;

         case (st)
            IDLE: begin
               // crash is deliberately ignored here, even on the start cycle
               if (start_edge) begin
                  st       <= PLAY;
                  score_0  <= 8'd0;
                  score_1  <= 8'd0;
                  mode_lat <= sk.mode;
               end
            end
            PLAY: begin
               score_0 <= score_0_nxt;
               score_1 <= score_1_nxt;
               if (crash_q) st <= OVER;
            end
            OVER: begin
               if (start_edge) st <= IDLE;
            end
            default: st <= IDLE;
         endcase

         // A new frame always (re)starts the conversion, aborting any in flight.
         if (sk.frame_tick) begin
            sk.binary    <= bin_nxt;
            sk.binary_1  <= mode_lat ? score_1 : 8'd0;
            sk.mode_out  <= mode_lat;
            sk.bcd_valid <= 1'b0;
            conv         <= {12'd0, bin_nxt};
            conv_cnt     <= 4'd8;
            conv_busy    <= 1'b1;
         end else if (conv_busy) begin
            if (conv_cnt != 4'd0) begin
               conv     <= bcd_step(conv);
               conv_cnt <= conv_cnt - 4'd1;
            end else begin
               sk.bcd_digits <= conv[19:8];
               sk.bcd_valid  <= 1'b1;
               conv_busy     <= 1'b0;
            end
         end
      end
   end

   assign sk.state = st;

endmodule

// File: tb/tb_score_keeper.sv
module tb_score_keeper;

   logic clk;
   logic rst;
   int   vectors;
   int   miscompares;

   score_keeper_if sk ();

   score_keeper dut (
      .clk (clk),
      .rst (rst),
      .sk  (sk)
   );

`ifdef HIGH_SCORE_EN
   localparam logic [7:0]  HS_EXP     = 8'd42;
   localparam logic [11:0] HS_BCD_EXP = 12'h042;
`else
   localparam logic [7:0]  HS_EXP     = 8'd0;
   localparam logic [11:0] HS_BCD_EXP = 12'h000;
`endif

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse_pass(input logic p0, input logic p1);
      sk.pass_0 = p0;
      sk.pass_1 = p1;
      tick(1);
      sk.pass_0 = 1'b0;
      sk.pass_1 = 1'b0;
      tick(1);
   endtask

   task automatic pulse_start();
      sk.start = 1'b1;
      tick(1);
      sk.start = 1'b0;
      tick(1);
   endtask

   task automatic do_crash();
      sk.crash = 1'b1;
      tick(2);
      sk.crash = 1'b0;
   endtask

   task automatic do_frame();
      sk.frame_tick = 1'b1;
      tick(1);
      sk.frame_tick = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick(2);
      rst = 1'b0;
      tick(1);
      vectors++; if (sk.state !== 2'b00) begin miscompares++; $display("FAIL rst_state: got %0b expected 00", sk.state); end
      vectors++; if (sk.binary !== 8'd0) begin miscompares++; $display("FAIL rst_binary: got %0d expected 0", sk.binary); end
      vectors++; if (sk.binary_1 !== 8'd0) begin miscompares++; $display("FAIL rst_binary_1: got %0d expected 0", sk.binary_1); end
      vectors++; if (sk.mode_out !== 1'b0) begin miscompares++; $display("FAIL rst_mode_out: got %0b expected 0", sk.mode_out); end
      vectors++; if (sk.bcd_digits !== 12'h000) begin miscompares++; $display("FAIL rst_bcd: got %03h expected 000", sk.bcd_digits); end
      vectors++; if (sk.bcd_valid !== 1'b1) begin miscompares++; $display("FAIL rst_bcd_valid: got %0b expected 1", sk.bcd_valid); end
   endtask

   task automatic test_single_player();
      sk.mode = 1'b0;
      pulse_start();
      vectors++; if (sk.state !== 2'b01) begin miscompares++; $display("FAIL sp_state: got %0b expected 01", sk.state); end
      for (int i = 0; i < 3; i++) pulse_pass(1'b1, 1'b1);
      do_frame();
      vectors++; if (sk.binary !== 8'd3) begin miscompares++; $display("FAIL sp_binary: got %0d expected 3", sk.binary); end
      vectors++; if (sk.binary_1 !== 8'd0) begin miscompares++; $display("FAIL sp_binary_1: got %0d expected 0", sk.binary_1); end
      vectors++; if (sk.bcd_valid !== 1'b0) begin miscompares++; $display("FAIL sp_valid_drop: got %0b expected 0", sk.bcd_valid); end
      vectors++; if (sk.bcd_digits !== 12'h000) begin miscompares++; $display("FAIL sp_bcd_hold: got %03h expected 000", sk.bcd_digits); end
      tick(8);
      vectors++; if (sk.bcd_valid !== 1'b0) begin miscompares++; $display("FAIL sp_valid_early: got %0b expected 0", sk.bcd_valid); end
      tick(1);
      vectors++; if (sk.bcd_valid !== 1'b1) begin miscompares++; $display("FAIL sp_valid_9: got %0b expected 1", sk.bcd_valid); end
      vectors++; if (sk.bcd_digits !== 12'h003) begin miscompares++; $display("FAIL sp_bcd: got %03h expected 003", sk.bcd_digits); end
   endtask

   task automatic test_frame_stable();
      pulse_pass(1'b1, 1'b0);
      pulse_pass(1'b1, 1'b0);
      tick(3);
      vectors++; if (sk.binary !== 8'd3) begin miscompares++; $display("FAIL fs_hold: got %0d expected 3", sk.binary); end
      do_frame();
      vectors++; if (sk.binary !== 8'd5) begin miscompares++; $display("FAIL fs_update: got %0d expected 5", sk.binary); end
      tick(9);
      vectors++; if (sk.bcd_digits !== 12'h005) begin miscompares++; $display("FAIL fs_bcd: got %03h expected 005", sk.bcd_digits); end
   endtask

   task automatic test_restart();
      do_frame();
      pulse_pass(1'b1, 1'b0);
      tick(1);
      do_frame();
      vectors++; if (sk.binary !== 8'd6) begin miscompares++; $display("FAIL rs_binary: got %0d expected 6", sk.binary); end
      tick(8);
      vectors++; if (sk.bcd_valid !== 1'b0) begin miscompares++; $display("FAIL rs_valid_early: got %0b expected 0", sk.bcd_valid); end
      tick(1);
      vectors++; if (sk.bcd_valid !== 1'b1) begin miscompares++; $display("FAIL rs_valid: got %0b expected 1", sk.bcd_valid); end
      vectors++; if (sk.bcd_digits !== 12'h006) begin miscompares++; $display("FAIL rs_bcd: got %03h expected 006", sk.bcd_digits); end
      do_crash();
      vectors++; if (sk.state !== 2'b10) begin miscompares++; $display("FAIL rs_over: got %0b expected 10", sk.state); end
   endtask

   task automatic test_high_score();
      pulse_start();
      vectors++; if (sk.state !== 2'b00) begin miscompares++; $display("FAIL hs_idle1: got %0b expected 00", sk.state); end
      pulse_start();
      for (int i = 0; i < 42; i++) pulse_pass(1'b1, 1'b0);
      do_crash();
      do_frame();
      vectors++; if (sk.binary !== 8'd42) begin miscompares++; $display("FAIL hs_over_binary: got %0d expected 42", sk.binary); end
      pulse_start();
      vectors++; if (sk.state !== 2'b00) begin miscompares++; $display("FAIL hs_idle2: got %0b expected 00", sk.state); end
      do_frame();
      vectors++; if (sk.binary !== HS_EXP) begin miscompares++; $display("FAIL hs_idle_binary: got %0d expected %0d", sk.binary, HS_EXP); end
      tick(9);
      vectors++; if (sk.bcd_digits !== HS_BCD_EXP) begin miscompares++; $display("FAIL hs_bcd: got %03h expected %03h", sk.bcd_digits, HS_BCD_EXP); end
   endtask

   task automatic test_saturation();
      sk.mode = 1'b1;
      pulse_start();
      for (int i = 0; i < 260; i++) pulse_pass(1'b1, 1'b1);
      do_frame();
      vectors++; if (sk.binary !== 8'd255) begin miscompares++; $display("FAIL sat_binary: got %0d expected 255", sk.binary); end
      vectors++; if (sk.binary_1 !== 8'd255) begin miscompares++; $display("FAIL sat_binary_1: got %0d expected 255", sk.binary_1); end
      vectors++; if (sk.mode_out !== 1'b1) begin miscompares++; $display("FAIL sat_mode_out: got %0b expected 1", sk.mode_out); end
      tick(9);
      vectors++; if (sk.bcd_digits !== 12'h255) begin miscompares++; $display("FAIL sat_bcd: got %03h expected 255", sk.bcd_digits); end
      vectors++; if (sk.bcd_valid !== 1'b1) begin miscompares++; $display("FAIL sat_valid: got %0b expected 1", sk.bcd_valid); end
   endtask

   task automatic test_crash_start();
      do_crash();
      pulse_start();
      vectors++; if (sk.state !== 2'b00) begin miscompares++; $display("FAIL cs_idle: got %0b expected 00", sk.state); end
      sk.start = 1'b1;
      sk.crash = 1'b1;
      tick(1);
      sk.start = 1'b0;
      tick(1);
      vectors++; if (sk.state !== 2'b01) begin miscompares++; $display("FAIL cs_play: got %0b expected 01", sk.state); end
      tick(1);
      vectors++; if (sk.state !== 2'b10) begin miscompares++; $display("FAIL cs_over: got %0b expected 10", sk.state); end
      sk.crash = 1'b0;
   endtask

   task automatic test_reset_mid_game();
      pulse_start();
      pulse_start();
      pulse_pass(1'b1, 1'b0);
      pulse_pass(1'b1, 1'b0);
      do_frame();
      vectors++; if (sk.binary !== 8'd2) begin miscompares++; $display("FAIL rm_pre_binary: got %0d expected 2", sk.binary); end
      sk.pass_0 = 1'b1;
      tick(1);
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      sk.pass_0 = 1'b0;
      vectors++; if (sk.state !== 2'b00) begin miscompares++; $display("FAIL rm_state: got %0b expected 00", sk.state); end
      vectors++; if (sk.binary !== 8'd0) begin miscompares++; $display("FAIL rm_binary: got %0d expected 0", sk.binary); end
      vectors++; if (sk.mode_out !== 1'b0) begin miscompares++; $display("FAIL rm_mode_out: got %0b expected 0", sk.mode_out); end
      vectors++; if (sk.bcd_valid !== 1'b1) begin miscompares++; $display("FAIL rm_valid: got %0b expected 1", sk.bcd_valid); end
      vectors++; if (sk.bcd_digits !== 12'h000) begin miscompares++; $display("FAIL rm_bcd: got %03h expected 000", sk.bcd_digits); end
      tick(3);
      do_frame();
      tick(9);
      vectors++; if (sk.binary !== 8'd0) begin miscompares++; $display("FAIL rm_post_binary: got %0d expected 0", sk.binary); end
      vectors++; if (sk.bcd_digits !== 12'h000) begin miscompares++; $display("FAIL rm_post_bcd: got %03h expected 000", sk.bcd_digits); end
   endtask

   initial begin
      vectors       = 0;
      miscompares   = 0;
      rst           = 1'b1;
      sk.mode       = 1'b0;
      sk.start      = 1'b0;
      sk.pass_0     = 1'b0;
      sk.pass_1     = 1'b0;
      sk.crash      = 1'b0;
      sk.frame_tick = 1'b0;
      test_reset();
      test_single_player();
      test_frame_stable();
      test_restart();
      test_high_score();
      test_saturation();
      test_crash_start();
      test_reset_mid_game();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
